pspin_cmd_arbiter: RTL and testbench

Shares the command interfaces (host-direct, NIC outbound, eDMA) between the HPUs of one cluster. The block round-robin arbitrates `pspin_cmd_t` requests from all cores and routes each one to the interface named by its `intf_id`. It enforces the per-HPU in-flight limit of `NUM_HPU_CMDS` by counting issued commands against completions. It sits between the cluster's HPU drivers and the cmd unit inputs.

---
 rtl/pspin_cmd_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_pspin_cmd_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pspin_cmd_arbiter.sv
// pspin_cmd_arbiter
//
// Shares the cluster command interfaces (host-direct, NIC outbound, eDMA)
// between the HPUs of one cluster. Requests from all HPUs are arbitrated
// round-robin, one grant per cycle. Each granted command is routed into a
// single-entry output slot for the interface named by its intf id.
// Per-requester in-flight counts are kept: a grant increments the count and
// a completion decrements it, and a requester at MAX_OUTSTANDING is held off.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   cmd_valid_i       per-HPU request valid
//   cmd_ready_o       per-HPU accept (combinational, one-hot or zero)
//   cmd_data_i        per-HPU flattened pspin_cmd_t payloads
//   cmd_intf_i        per-HPU target interface id
//   intf_valid_o      per-interface output slot valid
//   intf_ready_i      per-interface accept
//   intf_data_o       per-interface routed command
//   intf_src_o        per-interface originating requester
//   cmpl_valid_i      per-interface completion strobe
//   cmpl_src_i        per-interface requester of the completed command
//   inflight_o        per-requester in-flight count
//   err_o             one-cycle pulse: invalid intf id or completion underflow
//
// Optional build macro
//   PSPIN_CMD_ARB_STATS_EN  adds stats_issued_o, one 32-bit wrapping
//                           handshake counter per interface.

module pspin_cmd_arbiter #(
    parameter int NUM_REQ         = 8,
    parameter int NUM_INTF        = 3,
    parameter int CMD_W           = 640,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SRC_W           = $clog2(NUM_REQ),
    parameter int IID_W           = $clog2(NUM_INTF)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NUM_REQ-1:0]                            cmd_valid_i,
    output logic [NUM_REQ-1:0]                            cmd_ready_o,
    input  logic [NUM_REQ*CMD_W-1:0]                      cmd_data_i,
    input  logic [NUM_REQ*IID_W-1:0]                      cmd_intf_i,
    output logic [NUM_INTF-1:0]                           intf_valid_o,
    input  logic [NUM_INTF-1:0]                           intf_ready_i,
    output logic [NUM_INTF*CMD_W-1:0]                     intf_data_o,
    output logic [NUM_INTF*SRC_W-1:0]                     intf_src_o,
    input  logic [NUM_INTF-1:0]                           cmpl_valid_i,
    input  logic [NUM_INTF*SRC_W-1:0]                     cmpl_src_i,
    output logic [NUM_REQ*$clog2(MAX_OUTSTANDING+1)-1:0]  inflight_o,
    output logic                                          err_o
`ifdef PSPIN_CMD_ARB_STATS_EN
    ,
    output logic [NUM_INTF*32-1:0]                        stats_issued_o
`endif
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING+1);
    localparam int NUM_ID = 2**IID_W;

    logic [CNT_W-1:0]  inflight_q [NUM_REQ];
    logic [CNT_W-1:0]  inflight_d [NUM_REQ];
    logic [SRC_W-1:0]  rr_q;

    logic [NUM_ID-1:0]  slot_free;
    logic [NUM_REQ-1:0] elig;
    logic               gnt_found;
    logic [SRC_W-1:0]   gnt_idx;
    logic [IID_W-1:0]   gnt_tgt;
    logic               gnt_route;
    logic               gnt_drop;
    logic               underflow;
    logic               err_d;
    int                 rr_idx;
    int                 cmpl_cnt;
    int                 cnt_pre;

    // Eligibility. Ids that name no interface have no slot to wait on, so
    // their entry in slot_free stays 1 and only the credit check applies.
    always_comb begin
        slot_free = '1;
        elig      = '0;
        for (int t = 0; t < NUM_INTF; t++) begin
            slot_free[t] = !intf_valid_o[t] || intf_ready_i[t];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = cmd_valid_i[i]
                   && (int'(inflight_q[i]) < MAX_OUTSTANDING)
                   && slot_free[cmd_intf_i[i*IID_W +: IID_W]];
        end
    end

    // Round-robin pick: first eligible index at or after rr_q, with wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = int'(rr_q) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!gnt_found && elig[rr_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(rr_idx);
            end
        end
    end

    always_comb begin
        cmd_ready_o = '0;
        gnt_tgt     = cmd_intf_i[int'(gnt_idx)*IID_W +: IID_W];
        gnt_route   = gnt_found && (int'(gnt_tgt) < NUM_INTF);
        gnt_drop    = gnt_found && !(int'(gnt_tgt) < NUM_INTF);
        if (gnt_found) begin
            cmd_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Credit bookkeeping: the routed grant and all completions aimed at one
    // requester are netted in a single update. A net below zero is an
    // underflow: clamp to 0 and flag it; other requesters update normally.
    // Dropped (invalid id) grants never take a credit.
    always_comb begin
        underflow = 1'b0;
        cmpl_cnt  = 0;
        cnt_pre   = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            cmpl_cnt = 0;
            for (int k = 0; k < NUM_INTF; k++) begin
                if (cmpl_valid_i[k] && (cmpl_src_i[k*SRC_W +: SRC_W] == SRC_W'(r))) begin
                    cmpl_cnt = cmpl_cnt + 1;
                end
            end
            cnt_pre = int'(inflight_q[r]);
            if (gnt_route && (gnt_idx == SRC_W'(r))) begin
                cnt_pre = cnt_pre + 1;
            end
            if (cnt_pre < cmpl_cnt) begin
                inflight_d[r] = '0;
                underflow     = 1'b1;
            end else begin
                inflight_d[r] = CNT_W'(cnt_pre - cmpl_cnt);
            end
        end
        err_d = gnt_drop || underflow;
    end

    // Register stage: output slots, credits, pointer and error pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q         <= '0;
            intf_valid_o <= '0;
            intf_data_o  <= '0;
            intf_src_o   <= '0;
            err_o        <= 1'b0;
            for (int r = 0; r < NUM_REQ; r++) begin
                inflight_q[r] <= '0;
            end
        end else begin
            if (gnt_found) begin
                rr_q <= (gnt_idx == SRC_W'(NUM_REQ-1)) ? '0 : gnt_idx + SRC_W'(1);
            end
            // A reload wins over the clear, which gives back-to-back issue
            // into a slot that is being drained in the same cycle.
            for (int t = 0; t < NUM_INTF; t++) begin
                if (gnt_route && (gnt_tgt == IID_W'(t))) begin
                    intf_valid_o[t]                 <= 1'b1;
                    intf_data_o[t*CMD_W +: CMD_W]   <= cmd_data_i[int'(gnt_idx)*CMD_W +: CMD_W];
                    intf_src_o[t*SRC_W +: SRC_W]    <= gnt_idx;
                end else if (intf_ready_i[t]) begin
                    intf_valid_o[t] <= 1'b0;
                end
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                inflight_q[r] <= inflight_d[r];
            end
            err_o <= err_d;
        end
    end

    always_comb begin
        inflight_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            inflight_o[r*CNT_W +: CNT_W] = inflight_q[r];
        end
    end

`ifdef PSPIN_CMD_ARB_STATS_EN
    logic [31:0] stats_q [NUM_INTF];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int t = 0; t < NUM_INTF; t++) begin
                stats_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_INTF; t++) begin
                if (intf_valid_o[t] && intf_ready_i[t]) begin
                    stats_q[t] <= stats_q[t] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stats_issued_o = '0;
        for (int t = 0; t < NUM_INTF; t++) begin
            stats_issued_o[t*32 +: 32] = stats_q[t];
        end
    end
`endif

endmodule

// File: tb/tb_pspin_cmd_arbiter.sv
// Directed testbench for pspin_cmd_arbiter (default build, default parameters).

module tb_pspin_cmd_arbiter;

    localparam int NUM_REQ         = 8;
    localparam int NUM_INTF        = 3;
    localparam int CMD_W           = 640;
    localparam int MAX_OUTSTANDING = 4;
    localparam int SRC_W           = 3;
    localparam int IID_W           = 2;
    localparam int CNT_W           = 3;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic [NUM_REQ-1:0]            cmd_valid_i;
    logic [NUM_REQ-1:0]            cmd_ready_o;
    logic [NUM_REQ*CMD_W-1:0]      cmd_data_i;
    logic [NUM_REQ*IID_W-1:0]      cmd_intf_i;
    logic [NUM_INTF-1:0]           intf_valid_o;
    logic [NUM_INTF-1:0]           intf_ready_i;
    logic [NUM_INTF*CMD_W-1:0]     intf_data_o;
    logic [NUM_INTF*SRC_W-1:0]     intf_src_o;
    logic [NUM_INTF-1:0]           cmpl_valid_i;
    logic [NUM_INTF*SRC_W-1:0]     cmpl_src_i;
    logic [NUM_REQ*CNT_W-1:0]      inflight_o;
    logic                          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    pspin_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_INTF(NUM_INTF), .CMD_W(CMD_W),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_data_i(cmd_data_i), .cmd_intf_i(cmd_intf_i),
        .intf_valid_o(intf_valid_o), .intf_ready_i(intf_ready_i),
        .intf_data_o(intf_data_o), .intf_src_o(intf_src_o),
        .cmpl_valid_i(cmpl_valid_i), .cmpl_src_i(cmpl_src_i),
        .inflight_o(inflight_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic int infl(input int r);
        return int'(inflight_o[r*CNT_W +: CNT_W]);
    endfunction

    function automatic int src_of(input int t);
        return int'(intf_src_o[t*SRC_W +: SRC_W]);
    endfunction

    function automatic logic [31:0] dat_of(input int t);
        return intf_data_o[t*CMD_W +: 32];
    endfunction

    task automatic set_req(input int i, input int intf, input logic v);
        cmd_valid_i[i]                  = v;
        cmd_intf_i[i*IID_W +: IID_W]    = IID_W'(intf);
        cmd_data_i[i*CMD_W +: CMD_W]    = CMD_W'(pat(i));
    endtask

    task automatic set_cmpl(input int k, input int src, input logic v);
        cmpl_valid_i[k]              = v;
        cmpl_src_i[k*SRC_W +: SRC_W] = SRC_W'(src);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_valid_i  = '0;
        cmd_data_i   = '0;
        cmd_intf_i   = '0;
        cmpl_valid_i = '0;
        cmpl_src_i   = '0;
        intf_ready_i = '1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        step();
        step();
        // Reset values
        check("rst_valid",    intf_valid_o, 3'b000);
        check("rst_inflight", inflight_o, 0);
        check("rst_err",      err_o, 1'b0);
        check("rst_ready",    cmd_ready_o, 8'h00);
        check("rst_data",     |intf_data_o, 1'b0);
        check("rst_src",      intf_src_o, 0);
        rst_i = 1'b0;
        step();

        // Single request: HPU 3 -> intf 1
        set_req(3, 1, 1'b1);
        #1;
        check("single_ready", cmd_ready_o, 8'h08);
        step();
        cmd_valid_i = '0;
        check("single_valid", intf_valid_o, 3'b010);
        check("single_src",   src_of(1), 3);
        check("single_data",  dat_of(1), pat(3));
        check("single_infl",  infl(3), 1);
        step();
        check("single_drain", intf_valid_o, 3'b000);
        set_cmpl(1, 3, 1'b1);
        step();
        cmpl_valid_i = '0;
        check("single_cmpl_infl", infl(3), 0);
        check("single_cmpl_err",  err_o, 1'b0);

        // Round-robin: all eight target intf 2
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 2, 1'b1);
        for (int c = 0; c < 9; c++) begin
            #1;
            check($sformatf("rr_gnt%0d", c), cmd_ready_o, 8'h01 << (c % 8));
            step();
            check($sformatf("rr_src%0d", c), src_of(2), c % 8);
        end
        cmd_valid_i = '0;
        check("rr_infl0", infl(0), 2);
        check("rr_infl7", infl(7), 1);
        check("rr_slot",  intf_valid_o, 3'b100);
        // Mid-operation reset acts without a clock edge
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_valid", intf_valid_o, 3'b000);
        check("midrst_infl",  inflight_o, 0);
        step();
        rst_i = 1'b0;

        // Credit limit on HPU 5
        do_reset();
        set_req(5, 0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("cred_gnt%0d", c), cmd_ready_o, 8'h20);
            step();
            check($sformatf("cred_infl%0d", c), infl(5), c + 1);
        end
        #1;
        check("cred_hold1", cmd_ready_o, 8'h00);
        step();
        #1;
        check("cred_hold2", cmd_ready_o, 8'h00);
        check("cred_at_max", infl(5), 4);
        set_cmpl(0, 5, 1'b1);
        #1;
        check("cred_hold_cmpl", cmd_ready_o, 8'h00);
        step();
        cmpl_valid_i = '0;
        check("cred_after_cmpl", infl(5), 3);
        #1;
        check("cred_regrant", cmd_ready_o, 8'h20);
        step();
        cmd_valid_i = '0;
        check("cred_back_max", infl(5), 4);

        // Backpressure on intf 0
        do_reset();
        intf_ready_i = 3'b110;
        set_req(1, 0, 1'b1);
        set_req(2, 0, 1'b1);
        set_req(4, 1, 1'b1);
        #1;
        check("bp_gnt1", cmd_ready_o, 8'h02);
        step();
        cmd_valid_i[1] = 1'b0;
        #1;
        check("bp_gnt4", cmd_ready_o, 8'h10);
        step();
        cmd_valid_i[4] = 1'b0;
        check("bp_valid",  intf_valid_o, 3'b011);
        check("bp_src0",   src_of(0), 1);
        check("bp_src1",   src_of(1), 4);
        #1;
        check("bp_blocked", cmd_ready_o, 8'h00);
        step();
        check("bp_stable_data", dat_of(0), pat(1));
        check("bp_stable_vld",  intf_valid_o, 3'b001);
        intf_ready_i = 3'b111;
        #1;
        check("bp_reload_gnt", cmd_ready_o, 8'h04);
        step();
        cmd_valid_i = '0;
        check("bp_reload_src",  src_of(0), 2);
        check("bp_reload_data", dat_of(0), pat(2));
        check("bp_reload_vld",  intf_valid_o, 3'b001);

        // Grant plus two completions to the same requester
        do_reset();
        set_req(2, 1, 1'b1);
        step();
        step();
        check("sim_pre", infl(2), 2);
        set_cmpl(0, 2, 1'b1);
        set_cmpl(1, 2, 1'b1);
        #1;
        check("sim_gnt", cmd_ready_o, 8'h04);
        step();
        clear_inputs();
        check("sim_net",  infl(2), 1);
        check("sim_err",  err_o, 1'b0);

        // Error cases
        do_reset();
        set_req(6, 3, 1'b1);
        #1;
        check("bad_id_gnt", cmd_ready_o, 8'h40);
        step();
        cmd_valid_i = '0;
        check("bad_id_err",   err_o, 1'b1);
        check("bad_id_valid", intf_valid_o, 3'b000);
        check("bad_id_infl",  infl(6), 0);
        step();
        check("bad_id_once",  err_o, 1'b0);
        set_cmpl(2, 7, 1'b1);
        step();
        cmpl_valid_i = '0;
        check("under_err",  err_o, 1'b1);
        check("under_infl", infl(7), 0);
        step();
        check("under_once", err_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
